// File: rtl/dmem_mmio_if.sv
// Core-to-data-memory bus plus console stream and GPIO pins.
// Latency: none, this is wiring only.
// Backpressure: tx_ready from the console consumer is the only backpressure.
interface dmem_mmio_if;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] gpio_out;

    // Core / testbench side
    modport master (
        output ALUResult, WriteData, MemWrite, tx_ready,
        input  ReadData, tx_valid, tx_data, gpio_out
    );

    // Memory stage side
    modport slave (
        input  ALUResult, WriteData, MemWrite, tx_ready,
        output ReadData, tx_valid, tx_data, gpio_out
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (console TX FIFO, cycle counter, GPIO) behind the core.
// Latency: loads are combinational (0 cycles); stores take effect at the clock edge.
// Backpressure: tx_ready pops the FIFO head; pushes into a full FIFO drop the byte and set overflow.
module dmem_mmio #(
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    dmem_mmio_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [31:0]   ram_q  [DEPTH_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   gpio_q, gpio_d;

    logic          is_mmio;
    logic [1:0]    sel;
    logic [AW-1:0] ram_idx;
    logic          wr_ram, wr_con, wr_stat, wr_cyc, wr_gpio;
    logic          empty, full, pop, push_ok;
    logic [7:0]    head;
    logic          unused_addr;

    // Address decode: bit 31 splits RAM from MMIO, bits [3:2] pick the MMIO register
    assign is_mmio = bus.ALUResult[31];
    assign sel     = bus.ALUResult[3:2];
    assign ram_idx = bus.ALUResult[AW+1:2];
    assign unused_addr = ^{bus.ALUResult[30:AW+2], bus.ALUResult[1:0]};

    assign wr_ram  = bus.MemWrite & ~is_mmio;
    assign wr_con  = bus.MemWrite &  is_mmio & (sel == 2'd0);
    assign wr_stat = bus.MemWrite &  is_mmio & (sel == 2'd1);
    assign wr_cyc  = bus.MemWrite &  is_mmio & (sel == 2'd2);
    assign wr_gpio = bus.MemWrite &  is_mmio & (sel == 2'd3);

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = ~empty & bus.tx_ready;
    assign push_ok = wr_con & (~full | pop);
    assign head    = fifo_q[rd_ptr_q];

    // Next-state for FIFO bookkeeping, overflow flag, cycle counter and GPIO
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A dropped push wins over a same-cycle STATUS clear
        if (wr_stat)           ovf_d = 1'b0;
        if (wr_con & ~push_ok) ovf_d = 1'b1;
        cycle_d = wr_cyc  ? bus.WriteData : cycle_q + 32'd1;
        gpio_d  = wr_gpio ? bus.WriteData : gpio_q;
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cycle_q  <= '0;
            gpio_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
            gpio_q   <= gpio_d;
        end
    end

    // Storage arrays are not reset; FIFO slots are only read while counted valid
    always_ff @(posedge clk) begin
        if (wr_ram)  ram_q[ram_idx]   <= bus.WriteData;
        if (push_ok) fifo_q[wr_ptr_q] <= bus.WriteData[7:0];
    end

    assign bus.tx_valid = ~empty;
    assign bus.tx_data  = empty ? 8'h00 : head;
    assign bus.gpio_out = gpio_q;

    // Load mux: pure function of the address and current state
    always_comb begin
        bus.ReadData = ram_q[ram_idx];
        if (is_mmio) begin
            case (sel)
                2'd0:    bus.ReadData = {24'b0, (empty ? 8'h00 : head)};
                2'd1:    bus.ReadData = {29'b0, ovf_q, full, empty};
                2'd2:    bus.ReadData = cycle_q;
                default: bus.ReadData = gpio_q;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;
    localparam int DEPTH = 64;
    localparam int FD    = 4;
    localparam logic [31:0] A_CON  = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_CYC  = 32'h8000_0008;
    localparam logic [31:0] A_GPIO = 32'h8000_000C;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] rd;
    logic [7:0]  eb;

    dmem_mmio_if bus();

    dmem_mmio #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Drive one store through one rising edge (called at posedge+1)
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        bus.ALUResult = addr;
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        @(posedge clk); #1;
        bus.MemWrite  = 1'b0;
    endtask

    // Combinational load sampled 1 time unit after presenting the address
    task automatic do_load(input logic [31:0] addr, output logic [31:0] data);
        bus.ALUResult = addr;
        #1;
        data = bus.ReadData;
    endtask

    task automatic test_reset();
        bus.ALUResult = A_STAT;
        bus.WriteData = '0;
        bus.MemWrite  = 1'b0;
        bus.tx_ready  = 1'b0;
        #2;
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %h want 0", bus.tx_valid); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
        total++; if (bus.gpio_out !== 32'h0) begin bad++; $display("FAIL rst_gpio: got %h want 0", bus.gpio_out); end
        total++; if (bus.ReadData !== 32'h1) begin bad++; $display("FAIL rst_status: got %h want 1", bus.ReadData); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_cycle();
        for (int k = 0; k < 4; k++) begin
            do_load(A_CYC, rd);
            total++; if (rd !== 32'(k)) begin bad++; $display("FAIL cycle_k%0d: got %h want %h", k, rd, 32'(k)); end
            @(posedge clk); #1;
        end
        do_store(A_CYC, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            do_load(A_CYC, rd);
            total++; if (rd !== 32'hFFFF_FFFE + 32'(k)) begin bad++; $display("FAIL cycle_wrap%0d: got %h want %h", k, rd, 32'hFFFF_FFFE + 32'(k)); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ram();
        do_store(32'h10, 32'hDEAD_BEEF);
        do_load(32'h10, rd);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd: got %h want deadbeef", rd); end
        do_load(32'h10 + DEPTH * 4, rd);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_alias: got %h want deadbeef", rd); end
        do_store(32'h13, 32'h1234_5678);
        do_load(32'h10, rd);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL ram_byteoff: got %h want 12345678", rd); end
        do_store(32'h20, 32'hA5A5_0001);
        bus.ALUResult = 32'h20; bus.WriteData = 32'h0BAD_0BAD; bus.MemWrite = 1'b0;
        @(posedge clk); #1;
        do_load(32'h20, rd);
        total++; if (rd !== 32'hA5A5_0001) begin bad++; $display("FAIL ram_nowrite: got %h want a5a50001", rd); end
    endtask

    task automatic test_gpio();
        do_store(32'h8ABC_DEFC, 32'h0000_00C3);
        total++; if (bus.gpio_out !== 32'hC3) begin bad++; $display("FAIL gpio_alias_out: got %h want c3", bus.gpio_out); end
        do_load(A_GPIO, rd);
        total++; if (rd !== 32'hC3) begin bad++; $display("FAIL gpio_rd: got %h want c3", rd); end
    endtask

    task automatic test_fifo_fill();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < FD; i++) begin
            eb = 8'h41 + 8'(i);
            do_store(A_CON, {24'hFFFFFF, eb});
            exp_q.push_back(eb);
        end
        do_load(A_STAT, rd);
        total++; if (rd !== 32'b010) begin bad++; $display("FAIL fill_status: got %h want 2", rd); end
        do_load(A_CON, rd);
        total++; if (rd !== 32'h41) begin bad++; $display("FAIL fill_con_rd: got %h want 41", rd); end
        total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin bad++; $display("FAIL fill_head: got %h/%h want 1/41", bus.tx_valid, bus.tx_data); end
        do_store(A_CON, 32'h45);
        do_load(A_STAT, rd);
        total++; if (rd !== 32'b110) begin bad++; $display("FAIL ovf_status: got %h want 6", rd); end
        do_store(A_STAT, 32'h0);
        do_load(A_STAT, rd);
        total++; if (rd !== 32'b010) begin bad++; $display("FAIL ovf_clear: got %h want 2", rd); end
    endtask

    task automatic test_drain();
        bus.ALUResult = A_STAT;
        bus.tx_ready  = 1'b1;
        while (exp_q.size() > 0) begin
            #1;
            eb = exp_q.pop_front();
            total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== eb) begin bad++; $display("FAIL drain: got %h/%h want 1/%h", bus.tx_valid, bus.tx_data, eb); end
            @(posedge clk); #1;
        end
        bus.tx_ready = 1'b0;
        do_load(A_STAT, rd);
        total++; if (bus.tx_valid !== 1'b0 || rd !== 32'b001) begin bad++; $display("FAIL drain_end: got %h/%h want 0/1", bus.tx_valid, rd); end
    endtask

    task automatic test_full_push_pop();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < FD; i++) begin
            eb = 8'h61 + 8'(i);
            do_store(A_CON, {24'h0, eb});
            exp_q.push_back(eb);
        end
        bus.ALUResult = A_CON; bus.WriteData = 32'h55; bus.MemWrite = 1'b1; bus.tx_ready = 1'b1;
        #1;
        eb = exp_q.pop_front();
        total++; if (bus.tx_data !== eb) begin bad++; $display("FAIL fullpp_head: got %h want %h", bus.tx_data, eb); end
        exp_q.push_back(8'h55);
        @(posedge clk); #1;
        bus.MemWrite = 1'b0; bus.tx_ready = 1'b0;
        do_load(A_STAT, rd);
        total++; if (rd !== 32'b010) begin bad++; $display("FAIL fullpp_status: got %h want 2", rd); end
        test_drain();
    endtask

    task automatic test_wrap();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3 * FD + 1; i++) begin
            bus.ALUResult = A_CON; bus.WriteData = 32'(8'h70 + 8'(i)); bus.MemWrite = 1'b1;
            #1;
            total++; if (bus.tx_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL wrap_vld%0d: got %h want %h", i, bus.tx_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                eb = exp_q.pop_front();
                total++; if (bus.tx_data !== eb) begin bad++; $display("FAIL wrap_dat%0d: got %h want %h", i, bus.tx_data, eb); end
            end
            exp_q.push_back(8'h70 + 8'(i));
            @(posedge clk); #1;
        end
        bus.MemWrite = 1'b0;
        test_drain();
    endtask

    task automatic test_midreset();
        bus.tx_ready = 1'b0;
        do_store(32'h40, 32'hCAFE_F00D);
        do_store(A_GPIO, 32'h5A);
        for (int i = 0; i < 3; i++) do_store(A_CON, 32'h90 + 32'(i));
        do_load(A_STAT, rd);
        total++; if (rd !== 32'b000 || bus.gpio_out !== 32'h5A) begin bad++; $display("FAIL pre_rst: got %h/%h want 0/5a", rd, bus.gpio_out); end
        #1;
        reset = 1'b0;
        #1;
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_vld: got %h want 0", bus.tx_valid); end
        total++; if (bus.gpio_out !== 32'h0) begin bad++; $display("FAIL mid_rst_gpio: got %h want 0", bus.gpio_out); end
        total++; if (bus.ReadData !== 32'b001) begin bad++; $display("FAIL mid_rst_status: got %h want 1", bus.ReadData); end
        @(posedge clk); #1;
        reset = 1'b1;
        do_load(32'h40, rd);
        total++; if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL mid_rst_ram: got %h want cafef00d", rd); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ram();
        test_gpio();
        test_fifo_fill();
        test_drain();
        test_full_push_pop();
        test_wrap();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
